sct_state_seq: RTL and testbench
================================

// Module: sct_state_seq
// PURPOSE
//  Sequential state-holding stage wrapped around the sct next-state combinational block.
//  Holds the 8-bit sct state word (bits g..n) and drives it into the comb stage.
//  Captures the comb stage's next-state word under a req/ack step handshake.
//  Provides global clear (g0), parallel load and wrap detection.
// PARAMETERS
//  WIDTH   8  state word width; bit0=g ... bit7=n
//  SETTLE  1  cycles the state is held stable before ns_pad is sampled; range 1..15
// PORTS
//  clk_pad      in   1      single clock, rising edge
//  rst_n_pad    in   1      asynchronous, active-low reset
//  g0_pad       in   1      global enable; low = synchronous clear plus abort
//  step_req     in   1      level request for one state advance
//  step_ack     out  1      one-cycle pulse; the advance has been committed
//  load_pad     in   1      one-cycle strobe; load load_val into the state (IDLE only)
//  load_val     in   WIDTH  parallel load value
//  ns_pad       in   WIDTH  next-state word from the comb stage
//  state_q      out  WIDTH  registered state word, fed to the comb stage
//  busy         out  1      high in SETTLE and COMMIT
//  wrap         out  1      one-cycle pulse when a commit takes the state from all-ones to zero
// BEHAVIOUR
//  Reset (async, rst_n_pad=0):
//   - state_q=0, FSM=IDLE, settle counter=0.
//   - step_ack=0, busy=0, wrap=0.
//  FSM states: IDLE, SETTLE, COMMIT, WAITLOW.
//   - IDLE, load_pad=1: state_q<=load_val; no ack; stay in IDLE. load wins over step_req in the same cycle.
//   - IDLE, step_req=1 (no load): go to SETTLE with cnt<=SETTLE-1.
//   - SETTLE: cnt decrements; when cnt==0, go to COMMIT. state_q is held constant.
//   - COMMIT: state_q<=ns_pad; step_ack=1 for exactly this cycle.
//       - wrap=1 in the same cycle if old state_q==all-ones and ns_pad==0.
//       - Next state is WAITLOW.
//   - WAITLOW: hold until step_req=0, then go to IDLE.
//       - One advance per request assertion; a held request never auto-repeats.
//  Latency: step_req rising in IDLE -> step_ack after SETTLE+1 cycles (SETTLE=1 gives 2 cycles).
//  load_pad outside IDLE is ignored and not queued.
//  g0_pad=0, sampled in any state:
//   - state_q<=0 and FSM<=IDLE.
//   - step_ack, wrap and busy deassert next cycle.
//   - An in-flight step is dropped and never acked; the requester must re-raise step_req.
//   - g0 clear has priority over load and commit.
//  ns_pad is sampled only in COMMIT; its value in other states is don't-care.
//  All outputs are registered except busy, which is decoded from the FSM register.
// STRUCTURE
//  Package sct_pkg:
//   - WIDTH default.
//   - FSM state enum sct_seq_state_e (2 bits).
//   - Constant SCT_ALL_ONES.
//  Sub-module sct_settle_cnt: 4-bit loadable down-counter with a zero flag.
//  The comb next-state block is not instantiated here. The integrating top connects state_q -> comb -> ns_pad.
// TESTING
//  T1 reset: rst_n_pad=0 mid-COMMIT -> state_q=0, step_ack=0, busy=0 immediately, without waiting for a clock edge.
//  T2 step: state=8'h05, ns_pad=8'h06, step_req held high -> ack on cycle 2, state_q=8'h06, exactly one ack; release req -> IDLE.
//  T3 wrap: load 8'hFF, ns_pad=8'h00, step -> step_ack and wrap both high in the same cycle, state_q=0.
//  T4 simultaneous: load_pad=1, load_val=8'h3C, step_req=1 in IDLE -> state_q=8'h3C, no SETTLE entry, no ack that cycle.
//  T5 abort: g0_pad=0 during SETTLE -> state_q=0, FSM IDLE, no ack; re-raise step_req with g0=1 -> normal ack.
//  T6 SETTLE=4: request -> ack exactly 5 cycles later; ns_pad toggled during SETTLE -> only the COMMIT-cycle value is captured.

Source files
------------

// File: rtl/sct_pkg.sv
// Shared types and constants for the sct state sequencer.
package sct_pkg;

  localparam int SCT_WIDTH = 8;

  typedef enum logic [1:0] {
    SCT_IDLE    = 2'd0,
    SCT_SETTLE  = 2'd1,
    SCT_COMMIT  = 2'd2,
    SCT_WAITLOW = 2'd3
  } sct_seq_state_e;

  localparam logic [SCT_WIDTH-1:0] SCT_ALL_ONES = '1;

endpackage

// File: rtl/sct_settle_cnt.sv
// 4-bit loadable down-counter that times the settle window; zero flags expiry.
module sct_settle_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (clr) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/sct_state_seq.sv
// State register for the sct comb block: holds the state word, advances it
// from ns_pad under a req/ack handshake, with global clear, load and wrap flag.
module sct_state_seq
  import sct_pkg::*;
#(
  parameter int WIDTH  = SCT_WIDTH,
  parameter int SETTLE = 1
) (
  input  logic             clk_pad,
  input  logic             rst_n_pad,
  input  logic             g0_pad,
  input  logic             step_req,
  output logic             step_ack,
  input  logic             load_pad,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] ns_pad,
  output logic [WIDTH-1:0] state_q,
  output logic             busy,
  output logic             wrap
);

  localparam logic [3:0]       SETTLE_LD = 4'(SETTLE - 1);
  localparam logic [WIDTH-1:0] ALL_ONES  = '1;

  sct_seq_state_e fsm;
  logic           cnt_clr;
  logic           cnt_load;
  logic           cnt_dec;
  logic           cnt_zero;

  // Counter is armed on the same edge that accepts a request in IDLE.
  assign cnt_clr  = !g0_pad;
  assign cnt_load = g0_pad && (fsm == SCT_IDLE) && !load_pad && step_req;
  assign cnt_dec  = g0_pad && (fsm == SCT_SETTLE);

  sct_settle_cnt u_settle_cnt (
    .clk      (clk_pad),
    .rst_n    (rst_n_pad),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (SETTLE_LD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk_pad or negedge rst_n_pad) begin
    if (!rst_n_pad) begin
      fsm      <= SCT_IDLE;
      state_q  <= '0;
      step_ack <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      step_ack <= 1'b0;
      wrap     <= 1'b0;
      if (!g0_pad) begin
        // Clear aborts any in-flight step; it is never acked.
        fsm     <= SCT_IDLE;
        state_q <= '0;
      end else begin
        case (fsm)
          SCT_IDLE: begin
            if (load_pad) begin
              state_q <= load_val;
            end else if (step_req) begin
              fsm <= SCT_SETTLE;
            end
          end
          SCT_SETTLE: begin
            if (cnt_zero) fsm <= SCT_COMMIT;
          end
          SCT_COMMIT: begin
            state_q  <= ns_pad;
            step_ack <= 1'b1;
            wrap     <= (state_q == ALL_ONES) && (ns_pad == '0);
            fsm      <= SCT_WAITLOW;
          end
          SCT_WAITLOW: begin
            if (!step_req) fsm <= SCT_IDLE;
          end
          default: fsm <= SCT_IDLE;
        endcase
      end
    end
  end

  assign busy = (fsm == SCT_SETTLE) || (fsm == SCT_COMMIT);

endmodule

// File: tb/tb_sct_state_seq.sv
// Bench for sct_state_seq: vector table, hand sequences and a random run
// against a cycle-count reference model.
module tb_sct_state_seq;
  import sct_pkg::*;

  localparam int SETTLE1 = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       g0, req, load;
  logic [7:0] lval, ns, st;
  logic       ack, busy, wrap;

  logic       g04, req4, load4;
  logic [7:0] lval4, ns4, st4;
  logic       ack4, busy4, wrap4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sct_state_seq #(.WIDTH(8), .SETTLE(SETTLE1)) u_dut1 (
    .clk_pad(clk), .rst_n_pad(rst_n), .g0_pad(g0), .step_req(req),
    .step_ack(ack), .load_pad(load), .load_val(lval), .ns_pad(ns),
    .state_q(st), .busy(busy), .wrap(wrap)
  );

  sct_state_seq #(.WIDTH(8), .SETTLE(4)) u_dut4 (
    .clk_pad(clk), .rst_n_pad(rst_n), .g0_pad(g04), .step_req(req4),
    .step_ack(ack4), .load_pad(load4), .load_val(lval4), .ns_pad(ns4),
    .state_q(st4), .busy(busy4), .wrap(wrap4)
  );

  typedef struct {
    logic       g0;
    logic       req;
    logic       load;
    logic [7:0] lval;
    logic [7:0] ns;
    logic [7:0] e_st;
    logic       e_ack;
    logic       e_wrap;
    logic       e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic void addv(input logic g, input logic r, input logic l,
                               input logic [7:0] lv, input logic [7:0] n,
                               input logic [7:0] es, input logic ea,
                               input logic ew, input logic eb);
    vec_t v;
    v = '{g0: g, req: r, load: l, lval: lv, ns: n,
          e_st: es, e_ack: ea, e_wrap: ew, e_busy: eb};
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model state for the random run
  logic [7:0] m_st;
  int         age;
  bit         held;
  logic       e_ack, e_wrap, e_busy;

  initial begin
    rst_n = 1'b0;
    g0 = 1'b1; req = 1'b0; load = 1'b0; lval = 8'h00; ns = 8'h00;
    g04 = 1'b1; req4 = 1'b0; load4 = 1'b0; lval4 = 8'h00; ns4 = 8'h00;

    //          g0 rq ld lval   ns     st    ack wr busy
    addv(1, 0, 1, 8'h05, 8'h00, 8'h05, 0, 0, 0);
    addv(1, 1, 0, 8'h00, 8'h06, 8'h05, 0, 0, 1);
    addv(1, 1, 0, 8'h00, 8'h06, 8'h05, 0, 0, 1);
    addv(1, 1, 0, 8'h00, 8'h06, 8'h06, 1, 0, 0);
    addv(1, 1, 0, 8'h00, 8'h06, 8'h06, 0, 0, 0);
    addv(1, 1, 0, 8'h00, 8'h06, 8'h06, 0, 0, 0);
    addv(1, 0, 0, 8'h00, 8'h06, 8'h06, 0, 0, 0);
    addv(1, 1, 1, 8'h3C, 8'h99, 8'h3C, 0, 0, 0);
    addv(1, 0, 0, 8'h00, 8'h99, 8'h3C, 0, 0, 0);
    addv(1, 0, 1, 8'hFF, 8'h00, 8'hFF, 0, 0, 0);
    addv(1, 1, 0, 8'h00, 8'h00, 8'hFF, 0, 0, 1);
    addv(1, 1, 0, 8'h00, 8'h00, 8'hFF, 0, 0, 1);
    addv(1, 1, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0);
    addv(1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    addv(1, 0, 1, 8'hFF, 8'h01, 8'hFF, 0, 0, 0);
    addv(1, 1, 0, 8'h00, 8'h01, 8'hFF, 0, 0, 1);
    addv(1, 1, 0, 8'h00, 8'h01, 8'hFF, 0, 0, 1);
    addv(1, 1, 0, 8'h00, 8'h01, 8'h01, 1, 0, 0);
    addv(1, 0, 0, 8'h00, 8'h01, 8'h01, 0, 0, 0);
    addv(1, 0, 1, 8'hAA, 8'h00, 8'hAA, 0, 0, 0);
    addv(1, 1, 0, 8'h00, 8'h00, 8'hAA, 0, 0, 1);
    addv(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    addv(1, 1, 0, 8'h00, 8'h07, 8'h00, 0, 0, 1);
    addv(1, 1, 0, 8'h00, 8'h07, 8'h00, 0, 0, 1);
    addv(1, 1, 0, 8'h00, 8'h07, 8'h07, 1, 0, 0);
    addv(1, 0, 0, 8'h00, 8'h07, 8'h07, 0, 0, 0);
    addv(1, 1, 0, 8'h00, 8'h09, 8'h07, 0, 0, 1);
    addv(1, 1, 1, 8'h55, 8'h09, 8'h07, 0, 0, 1);
    addv(1, 1, 0, 8'h00, 8'h09, 8'h09, 1, 0, 0);
    addv(1, 0, 0, 8'h00, 8'h09, 8'h09, 0, 0, 0);
    addv(1, 1, 0, 8'h00, 8'h44, 8'h09, 0, 0, 1);
    addv(1, 1, 0, 8'h00, 8'h44, 8'h09, 0, 0, 1);
    addv(0, 1, 0, 8'h00, 8'h44, 8'h00, 0, 0, 0);
    addv(1, 0, 0, 8'h00, 8'h44, 8'h00, 0, 0, 0);
    addv(0, 0, 1, 8'h77, 8'h00, 8'h00, 0, 0, 0);
    addv(1, 0, 1, 8'h12, 8'h00, 8'h12, 0, 0, 0);

    #12;
    chk("rst_st", st, 8'h00);
    chk("rst_ack", ack, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wrap", wrap, 1'b0);
    chk("rst_st4", st4, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < tbl.size(); i++) begin
      g0 = tbl[i].g0; req = tbl[i].req; load = tbl[i].load;
      lval = tbl[i].lval; ns = tbl[i].ns;
      cyc();
      chk($sformatf("v%0d_st", i), st, tbl[i].e_st);
      chk($sformatf("v%0d_ack", i), ack, tbl[i].e_ack);
      chk($sformatf("v%0d_wrap", i), wrap, tbl[i].e_wrap);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
    end
    g0 = 1'b1; req = 1'b0; load = 1'b0;
    cyc();

    // SETTLE=4: ack five edges after acceptance, ns captured only at commit
    load4 = 1'b1; lval4 = 8'h05;
    cyc();
    load4 = 1'b0;
    chk("t6_load", st4, 8'h05);
    req4 = 1'b1; ns4 = 8'h00;
    cyc();
    chk("t6_busy0", busy4, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      ns4 = 8'(k * 17);
      cyc();
      chk($sformatf("t6_ack_k%0d", k), ack4, (k == 5) ? 1 : 0);
      if (k < 5) chk($sformatf("t6_busy_k%0d", k), busy4, 1'b1);
      if (k < 5) chk($sformatf("t6_hold_k%0d", k), st4, 8'h05);
      if (k == 5) chk("t6_capture", st4, 8'h55);
    end
    req4 = 1'b0;
    cyc();

    // Async reset while in COMMIT
    load = 1'b1; lval = 8'h5A;
    cyc();
    load = 1'b0; req = 1'b1; ns = 8'hC3;
    cyc();
    cyc();
    chk("t1_pre_busy", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_st", st, 8'h00);
    chk("t1_ack", ack, 1'b0);
    chk("t1_busy", busy, 1'b0);
    chk("t1_st4", st4, 8'h00);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random run against the reference model
    m_st = 8'h00; age = -1; held = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      g0   = ($urandom_range(0, 31) != 0);
      req  = ($urandom_range(0, 3) != 0) ? req : ~req;
      load = ($urandom_range(0, 7) == 0);
      lval = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      ns   = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      @(posedge clk);
      e_ack = 1'b0; e_wrap = 1'b0;
      if (!g0) begin
        m_st = 8'h00; age = -1; held = 1'b0;
      end else if (age >= 0) begin
        age++;
        if (age == SETTLE1 + 1) begin
          e_ack  = 1'b1;
          e_wrap = (m_st == SCT_ALL_ONES) && (ns == 8'h00);
          m_st   = ns;
          age    = -1;
          held   = 1'b1;
        end
      end else if (held) begin
        if (!req) held = 1'b0;
      end else if (load) begin
        m_st = lval;
      end else if (req) begin
        age = 0;
      end
      e_busy = (age >= 0);
      #1;
      chk($sformatf("r%0d_st", n), st, m_st);
      chk($sformatf("r%0d_ack", n), ack, e_ack);
      chk($sformatf("r%0d_wrap", n), wrap, e_wrap);
      chk($sformatf("r%0d_busy", n), busy, e_busy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
